// File: rtl/sc_player_ctrl_fsm.sv
// sc_player_ctrl_fsm: NUM_PLAYERS independent button FSMs producing clear / shift pulses.
// Optional macro SC_PLAYERCTRL_AUTOREPEAT_EN adds hold-to-repeat for left/right moves.
module sc_player_ctrl_fsm #(
   parameter int NUM_PLAYERS   = 2,
   parameter int REPEAT_DELAY  = 8,
   parameter int REPEAT_PERIOD = 4,
   parameter int CNT_W         = 8
) (
   input  logic                     SC_PLAYERCTRL_CLOCK_50,
   input  logic                     SC_PLAYERCTRL_RESET_InLow,
   input  logic                     SC_PLAYERCTRL_enable_InHigh,
   input  logic [NUM_PLAYERS-1:0]   SC_PLAYERCTRL_startButton_InLow,
   input  logic [NUM_PLAYERS-1:0]   SC_PLAYERCTRL_leftButton_InLow,
   input  logic [NUM_PLAYERS-1:0]   SC_PLAYERCTRL_rightButton_InLow,
   input  logic [NUM_PLAYERS-1:0]   SC_PLAYERCTRL_leftLimit_InLow,
   input  logic [NUM_PLAYERS-1:0]   SC_PLAYERCTRL_rightLimit_InLow,
   output logic [NUM_PLAYERS-1:0]   SC_PLAYERCTRL_clear_OutLow,
   output logic [2*NUM_PLAYERS-1:0] SC_PLAYERCTRL_shiftselection_Out,
   output logic [8*NUM_PLAYERS-1:0] SC_PLAYERCTRL_moveCount_Out
);

   typedef enum logic [2:0] {
      ST_RESET   = 3'd0,
      ST_IDLE    = 3'd1,
      ST_INIT    = 3'd2,
      ST_LEFT    = 3'd3,
      ST_RIGHT   = 3'd4,
      ST_RELEASE = 3'd5
   } state_t;

   state_t     state_q [NUM_PLAYERS];
   state_t     state_d [NUM_PLAYERS];
   logic [7:0] count_q [NUM_PLAYERS];
   logic [7:0] count_d [NUM_PLAYERS];

`ifdef SC_PLAYERCTRL_AUTOREPEAT_EN
   localparam logic [1:0] DIR_NONE  = 2'b00;
   localparam logic [1:0] DIR_LEFT  = 2'b01;
   localparam logic [1:0] DIR_RIGHT = 2'b10;

   logic [CNT_W-1:0] cnt_q [NUM_PLAYERS];
   logic [CNT_W-1:0] cnt_d [NUM_PLAYERS];
   logic [1:0]       dir_q [NUM_PLAYERS];
   logic [1:0]       dir_d [NUM_PLAYERS];
`endif

   // per-player state, move counter and repeat bookkeeping registers
   always_ff @(posedge SC_PLAYERCTRL_CLOCK_50 or negedge SC_PLAYERCTRL_RESET_InLow) begin
      if (!SC_PLAYERCTRL_RESET_InLow) begin
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            state_q[p] <= ST_RESET;
            count_q[p] <= 8'd0;
`ifdef SC_PLAYERCTRL_AUTOREPEAT_EN
            cnt_q[p]   <= '0;
            dir_q[p]   <= DIR_NONE;
`endif
         end
      end else begin
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            state_q[p] <= state_d[p];
            count_q[p] <= count_d[p];
`ifdef SC_PLAYERCTRL_AUTOREPEAT_EN
            cnt_q[p]   <= cnt_d[p];
            dir_q[p]   <= dir_d[p];
`endif
         end
      end
   end

   // next-state logic and state-decoded outputs for every player
   always_comb begin
      SC_PLAYERCTRL_clear_OutLow       = '1;
      SC_PLAYERCTRL_shiftselection_Out = '1;
      SC_PLAYERCTRL_moveCount_Out      = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         state_d[p] = state_q[p];
         count_d[p] = count_q[p];
`ifdef SC_PLAYERCTRL_AUTOREPEAT_EN
         cnt_d[p]   = cnt_q[p];
         dir_d[p]   = dir_q[p];
`endif
         SC_PLAYERCTRL_moveCount_Out[8*p +: 8] = count_q[p];
         case (state_q[p])
            ST_RESET: begin
               state_d[p] = ST_IDLE;
            end
            ST_IDLE: begin
               if (!SC_PLAYERCTRL_startButton_InLow[p]) begin
                  state_d[p] = ST_INIT;
               end else if (SC_PLAYERCTRL_enable_InHigh &&
                            !SC_PLAYERCTRL_leftButton_InLow[p] &&
                            SC_PLAYERCTRL_leftLimit_InLow[p]) begin
                  state_d[p] = ST_LEFT;
`ifdef SC_PLAYERCTRL_AUTOREPEAT_EN
                  cnt_d[p]   = CNT_W'(REPEAT_DELAY - 1);
`endif
               end else if (SC_PLAYERCTRL_enable_InHigh &&
                            !SC_PLAYERCTRL_rightButton_InLow[p] &&
                            SC_PLAYERCTRL_rightLimit_InLow[p]) begin
                  state_d[p] = ST_RIGHT;
`ifdef SC_PLAYERCTRL_AUTOREPEAT_EN
                  cnt_d[p]   = CNT_W'(REPEAT_DELAY - 1);
`endif
               end
            end
            ST_INIT: begin
               SC_PLAYERCTRL_clear_OutLow[p] = 1'b0;
               count_d[p] = 8'd0;
               state_d[p] = ST_RELEASE;
`ifdef SC_PLAYERCTRL_AUTOREPEAT_EN
               dir_d[p]   = DIR_NONE;
`endif
            end
            ST_LEFT: begin
               SC_PLAYERCTRL_shiftselection_Out[2*p +: 2] = 2'b01;
               count_d[p] = count_q[p] + 8'd1;
               state_d[p] = ST_RELEASE;
`ifdef SC_PLAYERCTRL_AUTOREPEAT_EN
               dir_d[p]   = DIR_LEFT;
`endif
            end
            ST_RIGHT: begin
               SC_PLAYERCTRL_shiftselection_Out[2*p +: 2] = 2'b10;
               count_d[p] = count_q[p] + 8'd1;
               state_d[p] = ST_RELEASE;
`ifdef SC_PLAYERCTRL_AUTOREPEAT_EN
               dir_d[p]   = DIR_RIGHT;
`endif
            end
            ST_RELEASE: begin
`ifdef SC_PLAYERCTRL_AUTOREPEAT_EN
               if (cnt_q[p] != '0) begin
                  cnt_d[p] = cnt_q[p] - CNT_W'(1);
               end
`endif
               if (SC_PLAYERCTRL_startButton_InLow[p] &&
                   SC_PLAYERCTRL_leftButton_InLow[p] &&
                   SC_PLAYERCTRL_rightButton_InLow[p]) begin
                  state_d[p] = ST_IDLE;
               end
`ifdef SC_PLAYERCTRL_AUTOREPEAT_EN
               // repeat only the last direction, held alone, unblocked
               else if (cnt_q[p] == '0 &&
                        SC_PLAYERCTRL_enable_InHigh &&
                        SC_PLAYERCTRL_startButton_InLow[p]) begin
                  if (dir_q[p] == DIR_LEFT &&
                      !SC_PLAYERCTRL_leftButton_InLow[p] &&
                      SC_PLAYERCTRL_rightButton_InLow[p] &&
                      SC_PLAYERCTRL_leftLimit_InLow[p]) begin
                     state_d[p] = ST_LEFT;
                     cnt_d[p]   = CNT_W'(REPEAT_PERIOD - 1);
                  end else if (dir_q[p] == DIR_RIGHT &&
                               !SC_PLAYERCTRL_rightButton_InLow[p] &&
                               SC_PLAYERCTRL_leftButton_InLow[p] &&
                               SC_PLAYERCTRL_rightLimit_InLow[p]) begin
                     state_d[p] = ST_RIGHT;
                     cnt_d[p]   = CNT_W'(REPEAT_PERIOD - 1);
                  end
               end
`endif
            end
            default: begin
               state_d[p] = ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sc_player_ctrl_fsm.sv
// tb_sc_player_ctrl_fsm: directed stimulus with an expected-event queue.
// Honours SC_PLAYERCTRL_AUTOREPEAT_EN when the build defines it.
module tb_sc_player_ctrl_fsm;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [1:0]  start;
   logic [1:0]  left;
   logic [1:0]  right;
   logic [1:0]  llim;
   logic [1:0]  rlim;
   logic [1:0]  clear;
   logic [3:0]  shift;
   logic [15:0] cnt;

   typedef struct {
      int         cyc;
      logic [1:0] clr;
      logic [3:0] sh;
   } ev_t;

   ev_t exp_q[$];
   ev_t mon_e;
   int  cyc = 0;
   int  vectors = 0;
   int  miscompares = 0;

`ifdef SC_PLAYERCTRL_AUTOREPEAT_EN
   localparam int HOLD = 5;
`else
   localparam int HOLD = 20;
`endif

   sc_player_ctrl_fsm #(
      .NUM_PLAYERS  (2),
      .REPEAT_DELAY (8),
      .REPEAT_PERIOD(4),
      .CNT_W        (8)
   ) dut (
      .SC_PLAYERCTRL_CLOCK_50          (clk),
      .SC_PLAYERCTRL_RESET_InLow       (rst_n),
      .SC_PLAYERCTRL_enable_InHigh     (en),
      .SC_PLAYERCTRL_startButton_InLow (start),
      .SC_PLAYERCTRL_leftButton_InLow  (left),
      .SC_PLAYERCTRL_rightButton_InLow (right),
      .SC_PLAYERCTRL_leftLimit_InLow   (llim),
      .SC_PLAYERCTRL_rightLimit_InLow  (rlim),
      .SC_PLAYERCTRL_clear_OutLow      (clear),
      .SC_PLAYERCTRL_shiftselection_Out(shift),
      .SC_PLAYERCTRL_moveCount_Out     (cnt)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // cycle index, sampled on the falling edge
   always @(posedge clk) cyc <= cyc + 1;

   // monitor: any non-idle output must match the next queued event
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            vectors++;
            miscompares++;
            $display("FAIL missing_event cyc=%0d got=none required clr=%b sh=%b",
                     exp_q[0].cyc, exp_q[0].clr, exp_q[0].sh);
            void'(exp_q.pop_front());
         end
         if (clear !== 2'b11 || shift !== 4'b1111) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_event cyc=%0d got clr=%b sh=%b required=idle",
                        cyc, clear, shift);
            end else begin
               mon_e = exp_q.pop_front();
               if (mon_e.cyc != cyc || mon_e.clr !== clear || mon_e.sh !== shift) begin
                  miscompares++;
                  $display("FAIL event got cyc=%0d clr=%b sh=%b required cyc=%0d clr=%b sh=%b",
                           cyc, clear, shift, mon_e.cyc, mon_e.clr, mon_e.sh);
               end
            end
         end
      end
   end

   // hard time limit
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input int c, input logic [1:0] cl, input logic [3:0] sh);
      ev_t e;
      e.cyc = c;
      e.clr = cl;
      e.sh  = sh;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
      vectors++;
      if (got !== req) begin
         miscompares++;
         $display("FAIL %s got=%0h required=%0h", nm, got, req);
      end
   endtask

   // directed stimulus
   initial begin
      rst_n = 1'b0;
      en    = 1'b1;
      start = 2'b11;
      left  = 2'b11;
      right = 2'b11;
      llim  = 2'b11;
      rlim  = 2'b11;
      wait_n(3);
      chk("rst_clear", 32'(clear), 32'h3);
      chk("rst_shift", 32'(shift), 32'hf);
      chk("rst_count", 32'(cnt), 32'h0);
      rst_n = 1'b1;

      // first press right after RESET->IDLE
      wait_n(1);
      left[0] = 1'b0;
      push(cyc + 1, 2'b11, 4'b1101);
      wait_n(HOLD);
      left[0] = 1'b1;
      wait_n(3);
      chk("p0_cnt_1", 32'(cnt[7:0]), 32'd1);
      left[0] = 1'b0;
      push(cyc + 1, 2'b11, 4'b1101);
      wait_n(3);
      left[0] = 1'b1;
      wait_n(3);
      chk("p0_cnt_2", 32'(cnt[7:0]), 32'd2);

      // both directions on P1: left wins
      left[1]  = 1'b0;
      right[1] = 1'b0;
      push(cyc + 1, 2'b11, 4'b0111);
      wait_n(3);
      left[1]  = 1'b1;
      right[1] = 1'b1;
      wait_n(3);
      chk("p1_cnt_1", 32'(cnt[15:8]), 32'd1);

      // P1 start and P0 right together
      start[1] = 1'b0;
      right[0] = 1'b0;
      push(cyc + 1, 2'b01, 4'b1110);
      wait_n(2);
      start[1] = 1'b1;
      right[0] = 1'b1;
      wait_n(3);
      chk("p1_cnt_clr", 32'(cnt[15:8]), 32'd0);
      chk("p0_cnt_3", 32'(cnt[7:0]), 32'd3);

      // blocked left, then limit releases while held
      llim[0] = 1'b0;
      left[0] = 1'b0;
      wait_n(5);
      llim[0] = 1'b1;
      push(cyc + 1, 2'b11, 4'b1101);
      wait_n(2);
      left[0] = 1'b1;
      wait_n(3);
      chk("p0_cnt_4", 32'(cnt[7:0]), 32'd4);

      // P0 right held 30 cycles
      right[0] = 1'b0;
      push(cyc + 1, 2'b11, 4'b1110);
`ifdef SC_PLAYERCTRL_AUTOREPEAT_EN
      push(cyc + 10, 2'b11, 4'b1110);
      push(cyc + 15, 2'b11, 4'b1110);
      push(cyc + 20, 2'b11, 4'b1110);
      push(cyc + 25, 2'b11, 4'b1110);
      push(cyc + 30, 2'b11, 4'b1110);
`endif
      wait_n(30);
      right[0] = 1'b1;
      wait_n(3);
`ifdef SC_PLAYERCTRL_AUTOREPEAT_EN
      chk("p0_cnt_hold", 32'(cnt[7:0]), 32'd10);
`else
      chk("p0_cnt_hold", 32'(cnt[7:0]), 32'd5);
`endif

      // enable low: moves ignored, start honoured
      en       = 1'b0;
      left[0]  = 1'b0;
      right[1] = 1'b0;
      wait_n(4);
      start[0] = 1'b0;
      push(cyc + 1, 2'b10, 4'b1111);
      wait_n(2);
      start[0] = 1'b1;
      left[0]  = 1'b1;
      right[1] = 1'b1;
      wait_n(2);
      en = 1'b1;
      wait_n(2);
      chk("dis_cnt0", 32'(cnt[7:0]), 32'd0);
      chk("dis_cnt1", 32'(cnt[15:8]), 32'd0);

      // async reset while a move is on the outputs
      right[1] = 1'b0;
      push(cyc + 1, 2'b11, 4'b1011);
      wait_n(1);
      #1;
      chk("pre_rst_shift", 32'(shift), 32'hb);
      rst_n = 1'b0;
      #1;
      chk("async_shift", 32'(shift), 32'hf);
      chk("async_clear", 32'(clear), 32'h3);
      chk("async_count", 32'(cnt), 32'h0);
      wait_n(1);
      right[1] = 1'b1;
      rst_n    = 1'b1;
      wait_n(3);
      chk("post_rst_cnt", 32'(cnt), 32'h0);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sc_player_ctrl_fsm.md
Name: sc_player_ctrl_fsm

Overview:
- Parametrised successor of the single-player button state machine.
- Runs NUM_PLAYERS independent per-player FSMs that turn active-low start/left/right buttons into a one-cycle clear pulse or one-cycle shift selection per press.
- Each player has separate left/right side-limit inputs.
- Optional hold-to-repeat for left/right moves.
- Sits between the debounced button synchronisers and the per-player shift registers / score logic.

Parameters:
- NUM_PLAYERS, 2, number of independent player channels (1..8).
- REPEAT_DELAY, 8, cycles a direction must stay held after the first move before the first auto-repeat.
- REPEAT_PERIOD, 4, cycles between subsequent auto-repeats while held.
- CNT_W, 8, repeat counter width. Must hold max(REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- SC_PLAYERCTRL_CLOCK_50  in  1  system clock.
- SC_PLAYERCTRL_RESET_InLow  in  1  asynchronous active-low reset.
- SC_PLAYERCTRL_enable_InHigh  in  1  game running. When low, moves are ignored; start is still accepted.
- SC_PLAYERCTRL_startButton_InLow  in  NUM_PLAYERS  per-player start/clear request.
- SC_PLAYERCTRL_leftButton_InLow  in  NUM_PLAYERS  per-player left request.
- SC_PLAYERCTRL_rightButton_InLow  in  NUM_PLAYERS  per-player right request.
- SC_PLAYERCTRL_leftLimit_InLow  in  NUM_PLAYERS  0 = player already at left edge; left move is blocked.
- SC_PLAYERCTRL_rightLimit_InLow  in  NUM_PLAYERS  0 = player already at right edge; right move is blocked.
- SC_PLAYERCTRL_clear_OutLow  out  NUM_PLAYERS  one-cycle active-low clear per player.
- SC_PLAYERCTRL_shiftselection_Out  out  2*NUM_PLAYERS  per-player field [2p+1:2p]. Encoding: 11 = hold, 01 = shift left, 10 = shift right.
- SC_PLAYERCTRL_moveCount_Out  out  8*NUM_PLAYERS  per-player 8-bit count of issued moves. Wraps 255 -> 0. Cleared by that player's INIT.

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Inputs are already synchronised and debounced upstream; no synchroniser inside.
- Reset state (applies to every player):
  - FSM in RESET.
  - clear_OutLow = all 1s.
  - shiftselection_Out = all 11.
  - moveCount = 0.
  - repeat counter = 0.
- Outputs are decoded combinationally from the registered state. A button sampled at edge k produces its output during cycle k+1.
- Per-player states: RESET, IDLE, INIT, LEFT, RIGHT, RELEASE.
- Transitions:
  - RESET -> IDLE unconditionally.
  - IDLE, checked in priority order:
    - start=0 -> INIT.
    - else enable=1 & left=0 & leftLimit=1 -> LEFT.
    - else enable=1 & right=0 & rightLimit=1 -> RIGHT.
    - else stay IDLE.
  - Left and right both pressed: left wins.
  - A blocked direction stays in IDLE. If the limit releases while the button is still held, the move then fires.
  - INIT: clear_OutLow[p]=0 for one cycle; moveCount[p] <= 0; -> RELEASE.
  - LEFT: field = 01 for one cycle; moveCount[p] += 1; -> RELEASE.
  - RIGHT: field = 10 for one cycle; moveCount[p] += 1; -> RELEASE.
  - RELEASE: all three buttons high -> IDLE; otherwise stay. Outputs are idle.
- Players are fully independent. Simultaneous events on different players are all serviced in the same cycle.
- enable dropping while a player is in LEFT/RIGHT: the move in progress completes.
- Reset asserted mid-operation: outputs return to reset values immediately (asynchronously).
- Unused state encodings -> IDLE with idle outputs.

Optional Feature:
- Macro: SC_PLAYERCTRL_AUTOREPEAT_EN.
- When defined:
  - Entering LEFT/RIGHT loads the counter with REPEAT_DELAY-1 on the first move and REPEAT_PERIOD-1 on repeats.
  - The counter decrements every cycle in RELEASE.
  - In RELEASE with counter==0 and the same direction button still low, with its limit high and enable=1: re-enter LEFT/RIGHT (a repeat).
  - A different button held, or the limit blocked, means wait for release.
  - Start is never repeated.
- When not defined: no counter is instantiated; RELEASE waits for full release only.

Test Plan:
- Reset low for 3 cycles, then release -> all clear_OutLow=1, shiftselection=4'b1111, moveCount=0; player FSMs reach IDLE 1 cycle after reset deasserts.
- P0 left low for 20 cycles with limits high, macro off -> exactly one cycle of [1:0]=01, moveCount[0]=1; after release and re-press, a second pulse and count=2.
- P1 start low while P0 right low in the same cycle -> same cycle: clear_OutLow=2'b01 and [1:0]=10; moveCount[1]=0, moveCount[0]=1.
- P0 left held with leftLimit=0 for 5 cycles, then leftLimit=1 -> no move while blocked; a single 01 pulse one cycle after the limit releases.
- Macro on, REPEAT_DELAY=8, REPEAT_PERIOD=4, P0 right held for 30 cycles -> pulses at relative cycles 1, 10, 15, 20, 25, 30 (first, +delay, then every period incl. the one-cycle move state).
- enable=0 with left and right pressed -> no shift pulses; start press still yields a one-cycle clear pulse and moveCount reset.
